// File: rtl/tcp_tx_framer_if.sv
// Byte-stream bundle around the framer: the transport-side input strobe/byte
// and the SiTCP transmit write port with its almost-full back-pressure.
interface tcp_tx_framer_if;
    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic       TCP_TX_FULL;
    logic       TCP_TX_WR;
    logic [7:0] TCP_TX_DATA;

    modport master (
        input  IN_VALID,
        input  IN_DATA,
        input  TCP_TX_FULL,
        output TCP_TX_WR,
        output TCP_TX_DATA
    );

    modport slave (
        output IN_VALID,
        output IN_DATA,
        output TCP_TX_FULL,
        input  TCP_TX_WR,
        input  TCP_TX_DATA
    );
endinterface

// File: rtl/tcp_tx_framer.sv
// Buffers the transport byte stream in a small FWFT FIFO and emits framed
// records (sync, sequence, length, payload, checksum) into the SiTCP TX port.
module tcp_tx_framer #(
    parameter int         PAYLOAD_LEN = 16,
    parameter int         FIFO_AW     = 6,
    parameter logic [7:0] HDR0        = 8'hAA,
    parameter logic [7:0] HDR1        = 8'h55
) (
    input  logic             CLK_200M,
    input  logic             SYS_RSTn,
    input  logic             ENABLE,
    tcp_tx_framer_if.master  tx,
    output logic [15:0]      SEQ_NUM,
    output logic [15:0]      DROP_CNT,
    output logic             BUSY
);

    localparam int               DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] LEN_C    = (FIFO_AW + 1)'(PAYLOAD_LEN);
    localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [7:0]       LEN_B    = 8'(PAYLOAD_LEN);
    localparam logic [7:0]       LAST_IDX = 8'(PAYLOAD_LEN - 1);

    typedef enum logic [2:0] {IDLE, H0, H1, SQH, SQL, LEN, PAY, CSUM} state_t;

    state_t             state_q, state_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [7:0]         idx_q, idx_d;
    logic [7:0]         sum_q, sum_d;
    logic [7:0]         data_q, data_d;
    logic               wr_q, wr_d;
    logic [15:0]        seq_q, seq_d;
    logic [15:0]        drop_q, drop_d;
    logic [7:0]         mem_q [DEPTH];

    logic [7:0] head;
    logic [7:0] emit_byte;
    logic       emit;
    logic       pop;
    logic       push;
    logic       fifo_full;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        fifo_full = (cnt_q == DEPTH_C);
        emit      = ENABLE && (state_q != IDLE) && !tx.TCP_TX_FULL;
        pop       = emit && (state_q == PAY);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push      = ENABLE && tx.IN_VALID && (!fifo_full || pop);

        case (state_q)
            H0:      emit_byte = HDR0;
            H1:      emit_byte = HDR1;
            SQH:     emit_byte = seq_q[15:8];
            SQL:     emit_byte = seq_q[7:0];
            LEN:     emit_byte = LEN_B;
            PAY:     emit_byte = head;
            CSUM:    emit_byte = ~sum_q;
            default: emit_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        data_d   = data_q;
        wr_d     = emit;
        seq_d    = seq_q;
        drop_d   = drop_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        if (ENABLE && tx.IN_VALID && fifo_full && !pop && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;

        if (emit) data_d = emit_byte;

        case (state_q)
            IDLE: begin
                if (ENABLE && (cnt_q >= LEN_C)) begin
                    state_d = H0;
                    idx_d   = 8'd0;
                    sum_d   = 8'd0;
                end
            end
            default: begin
                if (emit) begin
                    if (state_q inside {SQH, SQL, LEN, PAY})
                        sum_d = sum_q + emit_byte;
                    case (state_q)
                        H0:  state_d = H1;
                        H1:  state_d = SQH;
                        SQH: state_d = SQL;
                        SQL: state_d = LEN;
                        LEN: state_d = PAY;
                        PAY: begin
                            if (idx_q == LAST_IDX) begin
                                state_d = CSUM;
                                idx_d   = 8'd0;
                            end else begin
                                idx_d = idx_q + 8'd1;
                            end
                        end
                        CSUM: begin
                            state_d = IDLE;
                            seq_d   = seq_q + 16'd1;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase

        // Connection closed: abandon the frame and flush, but keep the drop tally.
        if (!ENABLE) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            idx_d    = 8'd0;
            sum_d    = 8'd0;
            seq_d    = 16'd0;
            wr_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK_200M or negedge SYS_RSTn) begin
        if (!SYS_RSTn) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            idx_q    <= 8'd0;
            sum_q    <= 8'd0;
            data_q   <= 8'h00;
            wr_q     <= 1'b0;
            seq_q    <= 16'd0;
            drop_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge CLK_200M) begin
        if (push) mem_q[wr_ptr_q] <= tx.IN_DATA;
    end

    assign tx.TCP_TX_WR   = wr_q;
    assign tx.TCP_TX_DATA = data_q;
    assign SEQ_NUM        = seq_q;
    assign DROP_CNT       = drop_q;
    assign BUSY           = (state_q != IDLE);

endmodule

// File: tb/tb_tcp_tx_framer.sv
// Scoreboard bench for tcp_tx_framer: a queue-based frame model predicts every
// TX byte, and an independent negedge monitor pops and compares each write.
module tb_tcp_tx_framer;

    localparam int L     = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [15:0] seq_num;
    logic [15:0] drop_cnt;
    logic        busy;

    tcp_tx_framer_if bus ();

    tcp_tx_framer #(
        .PAYLOAD_LEN (L),
        .FIFO_AW     (AW),
        .HDR0        (8'hAA),
        .HDR1        (8'h55)
    ) dut (
        .CLK_200M (clk),
        .SYS_RSTn (rstn),
        .ENABLE   (enable),
        .tx       (bus),
        .SEQ_NUM  (seq_num),
        .DROP_CNT (drop_cnt),
        .BUSY     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         pay;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  model_fifo[$];
    int          model_occ;
    logic [15:0] model_seq;
    int          model_drop;

    int errors;
    int checks;
    int cyc;
    int wr_cycles;
    int first_wr;
    int last_wr;
    int seen_cnt;
    bit rand_full;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Cuts complete frames out of the accepted byte list, as a frame is laid out on the wire.
    function automatic void frame_model();
        logic [7:0] sum;
        logic [7:0] p;
        while (model_fifo.size() >= L) begin
            sum = model_seq[15:8] + model_seq[7:0] + 8'(L);
            exp_q.push_back('{8'hAA, 1'b0});
            exp_q.push_back('{8'h55, 1'b0});
            exp_q.push_back('{model_seq[15:8], 1'b0});
            exp_q.push_back('{model_seq[7:0], 1'b0});
            exp_q.push_back('{8'(L), 1'b0});
            for (int i = 0; i < L; i++) begin
                p = model_fifo.pop_front();
                sum = sum + p;
                exp_q.push_back('{p, 1'b1});
            end
            exp_q.push_back('{~sum, 1'b0});
            model_seq = model_seq + 16'd1;
        end
    endfunction

    task automatic applyStimulus(input logic [7:0] d);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = d;
        if (enable) begin
            if (model_occ < DEPTH) begin
                model_occ++;
                model_fifo.push_back(d);
                frame_model();
            end else if (model_drop < 65535) begin
                model_drop++;
            end
        end
        @(posedge clk); #2;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic reset_meas();
        wr_cycles = 0;
        first_wr  = -1;
        last_wr   = -1;
        seen_cnt  = 0;
    endtask

    task automatic clear_model(input bit clear_drop);
        exp_q.delete();
        model_fifo.delete();
        model_occ = 0;
        model_seq = 16'd0;
        if (clear_drop) model_drop = 0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: %0d bytes outstanding, required 0", name, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.TCP_TX_WR === 1'b1) begin
            wr_cycles++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            seen_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_byte: got %0h, required no write", bus.TCP_TX_DATA);
            end else begin
                e = exp_q.pop_front();
                checkOutput("tx_byte", 32'(bus.TCP_TX_DATA), 32'(e.b));
                if (e.pay) model_occ--;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_full) begin
            #2;
            bus.TCP_TX_FULL = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rand_full = 1'b0;
        rstn      = 1'b0;
        enable    = 1'b0;
        bus.IN_VALID    = 1'b0;
        bus.IN_DATA     = 8'h00;
        bus.TCP_TX_FULL = 1'b0;
        clear_model(1'b1);
        reset_meas();

        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_wr",   32'(bus.TCP_TX_WR),   32'h0);
        checkOutput("reset_data", 32'(bus.TCP_TX_DATA), 32'h0);
        checkOutput("reset_seq",  32'(seq_num),         32'h0);
        checkOutput("reset_drop", 32'(drop_cnt),        32'h0);
        checkOutput("reset_busy", 32'(busy),            32'h0);
        rstn = 1'b1;
        @(posedge clk); #2;

        // Basic frame: AA 55 00 00 04 01 02 03 04 F1 back to back.
        enable = 1'b1;
        reset_meas();
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i));
        wait_drain("basic", 200);
        checkOutput("basic_wr_count", 32'(wr_cycles), 32'd10);
        checkOutput("basic_span", 32'(last_wr - first_wr + 1), 32'd10);
        checkOutput("basic_seq", 32'(seq_num), 32'd1);

        // Three-cycle stall right after the SQL byte.
        reset_meas();
        for (int i = 5; i <= 8; i++) applyStimulus(8'(i));
        n = 0;
        while (seen_cnt < 4 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("stall_reached_sql", 32'(seen_cnt), 32'd4);
        bus.TCP_TX_FULL = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        bus.TCP_TX_FULL = 1'b0;
        wait_drain("stall", 200);
        checkOutput("stall_wr_count", 32'(wr_cycles), 32'd10);
        checkOutput("stall_span", 32'(last_wr - first_wr + 1), 32'd13);
        checkOutput("stall_seq", 32'(seq_num), 32'(model_seq));

        // Overflow while SiTCP is full: 20 pushes into a 16-deep FIFO.
        reset_meas();
        bus.TCP_TX_FULL = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(8'(8'h40 + i));
        checkOutput("ovf_drop", 32'(drop_cnt), 32'(model_drop));
        checkOutput("ovf_drop_is_4", 32'(drop_cnt), 32'd4);
        checkOutput("ovf_busy", 32'(busy), 32'd1);
        checkOutput("ovf_no_write", 32'(wr_cycles), 32'd0);
        bus.TCP_TX_FULL = 1'b0;
        wait_drain("overflow", 400);
        checkOutput("ovf_wr_count", 32'(wr_cycles), 32'd40);

        // Continuous input: one idle cycle between consecutive frames.
        reset_meas();
        for (int i = 0; i < 16; i++) applyStimulus(8'($urandom_range(0, 255)));
        wait_drain("continuous", 400);
        checkOutput("cont_wr_count", 32'(wr_cycles), 32'd40);
        checkOutput("cont_span", 32'(last_wr - first_wr + 1), 32'd43);
        checkOutput("cont_drop", 32'(drop_cnt), 32'(model_drop));

        // Close the connection in the PAY state of the third frame.
        reset_meas();
        for (int i = 0; i < 12; i++) applyStimulus(8'($urandom_range(0, 255)));
        n = 0;
        while (seen_cnt < 25 && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        checkOutput("close_reached_pay", 32'(seen_cnt), 32'd25);
        enable = 1'b0;
        @(posedge clk); #2;
        clear_model(1'b0);
        @(negedge clk); #1;
        checkOutput("close_wr", 32'(bus.TCP_TX_WR), 32'h0);
        checkOutput("close_busy", 32'(busy), 32'h0);
        checkOutput("close_seq", 32'(seq_num), 32'(model_seq));
        checkOutput("close_drop_kept", 32'(drop_cnt), 32'(model_drop));
        @(posedge clk); #2;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom_range(0, 255)));
        wait_drain("reopen", 200);
        checkOutput("reopen_seq", 32'(seq_num), 32'd1);

        // Randomised payloads, gaps and back-pressure.
        rand_full = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < L; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #2;
                end
                applyStimulus(8'($urandom_range(0, 255)));
            end
            wait_drain("random", 600);
        end
        rand_full = 1'b0;
        @(posedge clk); #3;
        bus.TCP_TX_FULL = 1'b0;
        checkOutput("random_seq", 32'(seq_num), 32'(model_seq));
        checkOutput("random_drop", 32'(drop_cnt), 32'(model_drop));

        // Asynchronous reset in the middle of a frame.
        reset_meas();
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom_range(0, 255)));
        n = 0;
        while (seen_cnt < 3 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        rstn = 1'b0;
        #1;
        clear_model(1'b1);
        checkOutput("rst_mid_wr",   32'(bus.TCP_TX_WR),   32'h0);
        checkOutput("rst_mid_data", 32'(bus.TCP_TX_DATA), 32'h0);
        checkOutput("rst_mid_seq",  32'(seq_num),         32'(model_seq));
        checkOutput("rst_mid_drop", 32'(drop_cnt),        32'(model_drop));
        checkOutput("rst_mid_busy", 32'(busy),            32'h0);
        @(posedge clk); #2;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        checkOutput("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcp_tx_framer.md
Name: tcp_tx_framer

Overview:
Packetizing stage upstream of the SiTCP TCP transmit port (TCP_TX_WR / TCP_TX_DATA / TCP_TX_FULL). It accepts the 8-bit byte stream from the data-source (Transport) stage and buffers it in a small internal FIFO. It wraps each fixed-length payload into a framed record: sync header, sequence number, length, payload and checksum. It honours SiTCP back-pressure and counts bytes dropped on overflow.

Parameters:
PAYLOAD_LEN, 16, payload bytes per frame, legal 1..255
FIFO_AW, 6, input FIFO address width; depth = 2**FIFO_AW, must be >= PAYLOAD_LEN
HDR0, 8'hAA, first sync byte
HDR1, 8'h55, second sync byte

Ports:
CLK_200M  in  1  system clock
SYS_RSTn  in  1  reset
ENABLE  in  1  framing enable; tied to TCP_OPEN_ACK
IN_VALID  in  1  input byte strobe
IN_DATA  in  8  input byte
TCP_TX_FULL  in  1  SiTCP almost-full
TCP_TX_WR  out  1  write strobe to SiTCP
TCP_TX_DATA  out  8  byte to SiTCP
SEQ_NUM  out  16  sequence number of the next frame to be sent
DROP_CNT  out  16  dropped input bytes, saturating
BUSY  out  1  high while state != IDLE

Interface decision: reset SYS_RSTn, asynchronous, active-low; clock CLK_200M.

Behaviour:
- Reset values: TCP_TX_WR=0, TCP_TX_DATA=8'h00, SEQ_NUM=0, DROP_CNT=0, BUSY=0, FIFO empty, state IDLE.
- Input FIFO is first-word-fall-through and holds occupancy count CNT.
  - Write when IN_VALID && ENABLE && CNT < depth.
  - IN_VALID while full: byte discarded; DROP_CNT += 1, saturating at 16'hFFFF.
  - IN_VALID while ENABLE=0: byte ignored and not counted as dropped.
  - Simultaneous push and pop: CNT unchanged, and a push into a full FIFO in the same cycle as a pop is accepted.
- FSM states: IDLE, H0, H1, SQH, SQL, LEN, PAY, CSUM.
- IDLE -> H0 when ENABLE && CNT >= PAYLOAD_LEN.
- Every non-IDLE state emits exactly one byte. On each edge in a non-IDLE state:
  - If TCP_TX_FULL=0: TCP_TX_WR<=1, TCP_TX_DATA<=state byte, and the state advances.
  - If TCP_TX_FULL=1: TCP_TX_WR<=0, and state, payload index and checksum hold.
- State bytes:
  - H0=HDR0, H1=HDR1.
  - SQH=SEQ_NUM[15:8], SQL=SEQ_NUM[7:0].
  - LEN=PAYLOAD_LEN[7:0].
  - PAY = FIFO head; pop on emit. Stays in PAY for PAYLOAD_LEN emitted bytes, with the index counting 0..PAYLOAD_LEN-1.
  - CSUM = ~(sum mod 256 of the SQH, SQL, LEN and all payload bytes).
- CSUM emit -> IDLE; SEQ_NUM += 1 with wrap 16'hFFFF -> 0.
- TCP_TX_WR=0 in any cycle with no emit.
- Latency: first H0 byte appears on TCP_TX_WR one cycle after the qualifying IDLE cycle. A frame is PAYLOAD_LEN+6 bytes. There is exactly one idle cycle between back-to-back frames when TCP_TX_FULL=0.
- Payload is never underrun: the frame only starts with a full payload resident, and input writes cannot reduce CNT.
- TCP_TX_FULL toggling mid-frame: the byte sequence is identical to the no-stall case, only spread out in time.
- ENABLE falling (connection closed), on the next edge:
  - FSM returns to IDLE, FIFO is flushed, SEQ_NUM<=0, TCP_TX_WR<=0.
  - Any partial frame is abandoned.
  - DROP_CNT is retained.
- SYS_RSTn asserted mid-frame: all state is cleared immediately to reset values.

Test Plan:
1. PAYLOAD_LEN=4; ENABLE=1; push 01 02 03 04; TCP_TX_FULL=0 -> TCP_TX_WR stream AA 55 00 00 04 01 02 03 04 F1 on 10 consecutive cycles; SEQ_NUM=1 afterwards.
2. Same as 1, with TCP_TX_FULL high for 3 cycles after the SQL emit -> identical 10-byte stream; TCP_TX_WR low for exactly 3 cycles; no byte duplicated.
3. PAYLOAD_LEN=16, FIFO_AW=4; push 20 bytes in consecutive cycles with TCP_TX_FULL=1 held -> 16 buffered, DROP_CNT=4. Release FULL -> frame carries the first 16 bytes.
4. Force SEQ_NUM to 16'hFFFF via prior frames; send one frame -> SQH=FF, SQL=FF, and SEQ_NUM reads 0 afterwards.
5. Drop ENABLE during the PAY state of frame 3 -> TCP_TX_WR=0 the next cycle, BUSY=0, SEQ_NUM=0. Re-enable, push 4 bytes -> new frame carries sequence 00 00.
6. Continuous IN_VALID with PAYLOAD_LEN=4 -> frames separated by exactly one TCP_TX_WR=0 cycle; DROP_CNT stays 0.
